program_loader: RTL

- Upstream neighbour of `computer`. Receives a byte stream over a valid/ready handshake from the serial receiver.
- Assembles big-endian 16-bit instruction words and writes them sequentially into the instruction ROM's write port.
- Holds `computer` in reset until a complete image with a valid checksum has loaded.
- Replaces the hard-coded ROM image for board bring-up.

---
 rtl/loader_pkg.sv | 18 +
 rtl/program_loader_assembler.sv | 43 ++++
 rtl/program_loader.sv | 116 +++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and widths for the serial program loader.
// Frame: LEN_HI, LEN_LO, N big-endian words, then an XOR checksum byte.
package loader_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int BYTE_WIDTH = 8;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        CHECK,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/program_loader_assembler.sv
// Pairs accepted bytes into big-endian words and keeps the running XOR of the frame.
// The word and its ready pulse are registered, so they serve directly as the ROM write port.
module byte_word_assembler
    import loader_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [BYTE_WIDTH-1:0] data,
    input  logic                  take,
    input  logic                  take_hi,
    input  logic                  take_lo,
    output logic [WORD_WIDTH-1:0] word,
    output logic                  word_ready,
    output logic [BYTE_WIDTH-1:0] checksum
);

    logic [BYTE_WIDTH-1:0] hi_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hi_reg     <= '0;
            word       <= '0;
            word_ready <= 1'b0;
            checksum   <= '0;
        end else begin
            word_ready <= take && take_lo;
            if (clear) begin
                checksum <= '0;
            end else if (take) begin
                checksum <= checksum ^ data;
                if (take_hi) begin
                    hi_reg <= data;
                end
                // word only changes on a low byte, so it holds between writes
                if (take_lo) begin
                    word <= {hi_reg, data};
                end
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a checksummed instruction image into the ROM write port and holds
// the CPU in reset until the whole image has arrived and verified.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 15,
    parameter int MAX_WORDS  = 32768
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [BYTE_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic                  start,
    output logic                  rom_we,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [WORD_WIDTH-1:0] rom_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    state_t                  state_reg;
    logic [BYTE_WIDTH-1:0]   len_hi_reg;
    logic [WORD_WIDTH-1:0]   word_count_reg;
    logic [WORD_WIDTH-1:0]   index_reg;
    logic [WORD_WIDTH-1:0]   index_next;
    logic [WORD_WIDTH-1:0]   len_value;
    logic [BYTE_WIDTH-1:0]   checksum;
    logic                    accept;
    logic                    take;
    logic                    restart;

    assign accept     = rx_valid && rx_ready;
    assign take       = accept && (state_reg == LEN_HI || state_reg == LEN_LO ||
                                   state_reg == DATA_HI || state_reg == DATA_LO);
    assign restart    = start && (state_reg == DONE || state_reg == ERROR);
    assign index_next = index_reg + 16'd1;
    assign len_value  = {len_hi_reg, rx_data};

    byte_word_assembler u_assembler (
        .clock      (clock),
        .reset      (reset),
        .clear      (restart),
        .data       (rx_data),
        .take       (take),
        .take_hi    (state_reg == DATA_HI),
        .take_lo    (state_reg == DATA_LO),
        .word       (rom_wdata),
        .word_ready (rom_we),
        .checksum   (checksum)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= LEN_HI;
            len_hi_reg     <= '0;
            word_count_reg <= '0;
            index_reg      <= '0;
            rom_addr       <= '0;
            cpu_reset      <= 1'b1;
            done           <= 1'b0;
            error          <= 1'b0;
            rx_ready       <= 1'b1;
        end else begin
            case (state_reg)
                LEN_HI: if (accept) begin
                    len_hi_reg <= rx_data;
                    state_reg  <= LEN_LO;
                end
                LEN_LO: if (accept) begin
                    word_count_reg <= len_value;
                    if (len_value == '0) begin
                        state_reg <= CHECK;
                    end else if (int'(len_value) > MAX_WORDS) begin
                        // rejecting here also rules out any address wrap
                        state_reg <= ERROR;
                        error     <= 1'b1;
                        rx_ready  <= 1'b0;
                    end else begin
                        state_reg <= DATA_HI;
                    end
                end
                DATA_HI: if (accept) begin
                    state_reg <= DATA_LO;
                end
                DATA_LO: if (accept) begin
                    rom_addr  <= index_reg[ADDR_WIDTH-1:0];
                    index_reg <= index_next;
                    state_reg <= (index_next == word_count_reg) ? CHECK : DATA_HI;
                end
                CHECK: if (accept) begin
                    rx_ready <= 1'b0;
                    if (rx_data == checksum) begin
                        state_reg <= DONE;
                        done      <= 1'b1;
                        cpu_reset <= 1'b0;
                    end else begin
                        state_reg <= ERROR;
                        error     <= 1'b1;
                    end
                end
                DONE, ERROR: if (start) begin
                    state_reg <= LEN_HI;
                    done      <= 1'b0;
                    error     <= 1'b0;
                    cpu_reset <= 1'b1;
                    rx_ready  <= 1'b1;
                    index_reg <= '0;
                end
                default: state_reg <= LEN_HI;
            endcase
        end
    end

endmodule
